// File: rtl/voting_machine_param.sv
// Parametrised ballot machine: debounced candidate buttons, officer-armed
// single-vote ballots, saturating tallies, running total and leader/tie flags.
module voting_machine_param #(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int DEBOUNCE_CYC = 10,
    parameter int ACK_CYC      = 4,
    parameter int IDX_W        = $clog2(NUM_CAND),
    parameter int TOT_W        = CNT_W + $clog2(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                arm,
    input  logic [NUM_CAND-1:0] button,
    output logic [CNT_W-1:0]    led,
    output logic                vote_ack,
    output logic                spoiled,
    output logic                armed,
    output logic [TOT_W-1:0]    total,
    output logic [IDX_W-1:0]    leader,
    output logic                tie,
    output logic                saturated
);
    localparam int DC_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int AC_W = $clog2(ACK_CYC + 1);
    localparam int PC_W = $clog2(NUM_CAND + 1);
    localparam logic [DC_W-1:0]  DC_MAX    = DC_W'(DEBOUNCE_CYC);
    localparam logic [AC_W-1:0]  AC_LAST   = AC_W'(ACK_CYC - 1);
    localparam logic [CNT_W-1:0] TALLY_MAX = '1;

    typedef enum logic [1:0] {IDLE, ARMED, ACK} state_t;

    logic [NUM_CAND-1:0][DC_W-1:0]  dcnt_q, dcnt_d;
    logic [NUM_CAND-1:0]            held, held_dly_q, press_q, press_d;
    logic [NUM_CAND-1:0][CNT_W-1:0] tally_q, tally_d;
    logic [TOT_W-1:0]               total_q, total_d;
    logic                           sat_q, sat_d;
    state_t                         state_q, state_d;
    logic [AC_W-1:0]                ack_cnt_q, ack_cnt_d;
    logic                           vote_ack_q, vote_ack_d;
    logic                           spoiled_q, spoiled_d;
    logic                           armed_q, armed_d;
    logic [CNT_W-1:0]               led_q, led_d;
    logic [IDX_W-1:0]               leader_q, leader_d;
    logic                           tie_q, tie_d;

    logic [PC_W-1:0]  press_cnt, held_cnt, max_cnt;
    logic [IDX_W-1:0] press_idx, held_idx;
    logic [CNT_W-1:0] max_v;

    // Debounce: saturating run-length counter; a press fires once when the
    // run first reaches DEBOUNCE_CYC, so a new press needs a release.
    always_comb begin
        held    = '0;
        dcnt_d  = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            held[i] = (dcnt_q[i] == DC_MAX);
            if (!button[i])
                dcnt_d[i] = '0;
            else if (held[i])
                dcnt_d[i] = DC_MAX;
            else
                dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
        press_d = held & ~held_dly_q;
    end

    always_comb begin
        press_cnt = '0;
        press_idx = '0;
        held_cnt  = '0;
        held_idx  = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (press_q[i]) begin
                press_cnt = press_cnt + 1'b1;
                press_idx = IDX_W'(i);
            end
            if (held[i]) begin
                held_cnt = held_cnt + 1'b1;
                held_idx = IDX_W'(i);
            end
        end
    end

    // Leader scan: strict compare keeps the lowest index among equal maxima.
    always_comb begin
        max_v    = tally_q[0];
        leader_d = '0;
        max_cnt  = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally_q[i] > max_v) begin
                max_v    = tally_q[i];
                leader_d = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++)
            if (tally_q[i] == max_v)
                max_cnt = max_cnt + 1'b1;
        tie_d = (max_cnt > PC_W'(1));
    end

    always_comb begin
        state_d    = state_q;
        ack_cnt_d  = ack_cnt_q;
        tally_d    = tally_q;
        total_d    = total_q;
        sat_d      = sat_q;
        vote_ack_d = 1'b0;
        spoiled_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm && !mode)
                    state_d = ARMED;
            end
            ARMED: begin
                // Cancellation wins over any press sampled in the same cycle.
                if (mode) begin
                    state_d = IDLE;
                end else if (press_cnt == PC_W'(1)) begin
                    vote_ack_d = 1'b1;
                    state_d    = ACK;
                    ack_cnt_d  = '0;
                    if (tally_q[press_idx] != TALLY_MAX) begin
                        tally_d[press_idx] = tally_q[press_idx] + 1'b1;
                        total_d            = total_q + 1'b1;
                    end else begin
                        sat_d = 1'b1;
                    end
                end else if (press_cnt > PC_W'(1)) begin
                    spoiled_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            ACK: begin
                if (ack_cnt_q == AC_LAST)
                    state_d = IDLE;
                else
                    ack_cnt_d = ack_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // led follows the next state so the display tracks the FSM cycle-for-cycle.
    always_comb begin
        armed_d = (state_d == ARMED);
        led_d   = '0;
        if (mode) begin
            if (held_cnt == PC_W'(1))
                led_d = tally_q[held_idx];
        end else begin
            case (state_d)
                ARMED:   led_d = CNT_W'(1);
                ACK:     led_d = '1;
                default: led_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            dcnt_q     <= '0;
            held_dly_q <= '0;
            press_q    <= '0;
            tally_q    <= '0;
            total_q    <= '0;
            sat_q      <= 1'b0;
            state_q    <= IDLE;
            ack_cnt_q  <= '0;
            vote_ack_q <= 1'b0;
            spoiled_q  <= 1'b0;
            armed_q    <= 1'b0;
            led_q      <= '0;
            leader_q   <= '0;
            tie_q      <= 1'b1;
        end else begin
            dcnt_q     <= dcnt_d;
            held_dly_q <= held;
            press_q    <= press_d;
            tally_q    <= tally_d;
            total_q    <= total_d;
            sat_q      <= sat_d;
            state_q    <= state_d;
            ack_cnt_q  <= ack_cnt_d;
            vote_ack_q <= vote_ack_d;
            spoiled_q  <= spoiled_d;
            armed_q    <= armed_d;
            led_q      <= led_d;
            leader_q   <= leader_d;
            tie_q      <= tie_d;
        end
    end

    assign led       = led_q;
    assign vote_ack  = vote_ack_q;
    assign spoiled   = spoiled_q;
    assign armed     = armed_q;
    assign total     = total_q;
    assign leader    = leader_q;
    assign tie       = tie_q;
    assign saturated = sat_q;

endmodule

// File: tb/tb_voting_machine_param.sv
// Bench for voting_machine_param: per-cycle scoreboard fed by a rule-level
// reference model, plus directed scenarios and randomized ballots.
module tb_voting_machine_param;
    localparam int NC = 4;
    localparam int CW = 2;
    localparam int DB = 10;
    localparam int AK = 4;
    localparam int IW = 2;
    localparam int TW = CW + 2;
    localparam int MAXT = (1 << CW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mode  = 1'b0;
    logic          arm   = 1'b0;
    logic [NC-1:0] button = '0;
    logic [CW-1:0] led;
    logic          vote_ack, spoiled, armed, tie, saturated;
    logic [TW-1:0] total;
    logic [IW-1:0] leader;

    voting_machine_param #(
        .NUM_CAND(NC), .CNT_W(CW), .DEBOUNCE_CYC(DB), .ACK_CYC(AK)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode), .arm(arm), .button(button),
        .led(led), .vote_ack(vote_ack), .spoiled(spoiled), .armed(armed),
        .total(total), .leader(leader), .tie(tie), .saturated(saturated)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [CW-1:0] led;
        logic          ack;
        logic          spoil;
        logic          armed;
        logic [TW-1:0] total;
        logic [IW-1:0] lead;
        logic          tie;
        logic          sat;
    } obs_t;

    obs_t sb_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: run[i] counts consecutive high samples; a ballot
    // decision at an edge uses the presses announced at the previous edge.
    int run [NC];
    bit pv  [NC];
    int tly [NC];
    int phase = 0;     // 0 idle, 1 ballot open, 2 acknowledging
    int ack_left = 0;
    int tot = 0;
    bit sat_m = 0;

    always @(posedge clock) begin
        obs_t e;
        int np, pw, nh, hw, mx, nm, ledv, lead_m, res_led;
        bit vack, vsp, tie_m;
        vack = 0; vsp = 0;
        if (!reset) begin
            foreach (run[i]) begin run[i] = 0; pv[i] = 0; tly[i] = 0; end
            phase = 0; ack_left = 0; tot = 0; sat_m = 0;
            ledv = 0; lead_m = 0; tie_m = 1;
        end else begin
            mx = 0; lead_m = 0; nm = 0;
            foreach (tly[i]) if (tly[i] > mx) begin mx = tly[i]; lead_m = i; end
            foreach (tly[i]) if (tly[i] == mx) nm++;
            tie_m = (nm >= 2);
            np = 0; pw = 0; nh = 0; hw = 0;
            foreach (run[i]) begin
                if (pv[i]) begin np++; pw = i; end
                if (run[i] >= DB) begin nh++; hw = i; end
            end
            res_led = (nh == 1) ? tly[hw] : 0;
            if (phase == 0) begin
                if (arm && !mode) phase = 1;
            end else if (phase == 1) begin
                if (mode) phase = 0;
                else if (np == 1) begin
                    vack = 1; phase = 2; ack_left = AK;
                    if (tly[pw] < MAXT) begin tly[pw]++; tot++; end
                    else sat_m = 1;
                end else if (np > 1) begin
                    vsp = 1; phase = 0;
                end
            end else begin
                ack_left--;
                if (ack_left == 0) phase = 0;
            end
            foreach (run[i]) begin
                pv[i]  = (run[i] == DB);
                run[i] = button[i] ? run[i] + 1 : 0;
            end
            if (mode) ledv = res_led;
            else ledv = (phase == 0) ? 0 : (phase == 1) ? 1 : MAXT;
        end
        e.led = CW'(ledv); e.ack = vack; e.spoil = vsp; e.armed = (phase == 1);
        e.total = TW'(tot); e.lead = IW'(lead_m); e.tie = tie_m; e.sat = sat_m;
        sb_q.push_back(e);
    end

    always @(negedge clock) begin
        obs_t e, g;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            g = '{led, vote_ack, spoiled, armed, total, leader, tie, saturated};
            n_checks++;
            if (g === e) n_pass++;
            else $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, g, e);
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic arm1();
        arm = 1'b1; step(1); arm = 1'b0;
    endtask

    task automatic hold(input logic [NC-1:0] m, input int n);
        button = m; step(n); button = '0;
    endtask

    task automatic vote(input logic [NC-1:0] m, output logic ack);
        arm1(); hold(m, DB); step(2); ack = vote_ack; step(4);
    endtask

    task automatic do_reset();
        reset = 1'b0; step(1); reset = 1'b1;
    endtask

    logic          a;
    logic [NC-1:0] m;

    initial begin
        step(3);
        chk("rst_led", led, 0);  chk("rst_total", total, 0);
        chk("rst_leader", leader, 0); chk("rst_tie", tie, 1);
        chk("rst_sat", saturated, 0); chk("rst_armed", armed, 0);
        reset = 1'b1;

        // single accepted ballot for candidate 2
        arm1(); hold(4'b0100, DB); step(2);
        chk("t1_led_ack", led, MAXT); chk("t1_vote_ack", vote_ack, 1); chk("t1_total", total, 1);
        step(1);
        chk("t1_leader", leader, 2); chk("t1_tie", tie, 0); chk("t1_ack_width", vote_ack, 0);
        step(3);
        chk("t1_led_idle", led, 0);

        // short press is not a press; a full one is
        arm1(); hold(4'b0010, DB - 1); step(3);
        chk("t2_still_armed", armed, 1); chk("t2_no_vote", total, 1);
        hold(4'b0010, DB); step(2);
        chk("t2_total", total, 2); chk("t2_ack", vote_ack, 1);
        step(4);

        // simultaneous presses spoil the ballot
        arm1(); hold(4'b1001, DB); step(2);
        chk("t3_spoiled", spoiled, 1); chk("t3_no_ack", vote_ack, 0);
        chk("t3_idle", armed, 0); chk("t3_total", total, 2);
        step(1);
        chk("t3_spoil_width", spoiled, 0);

        // saturation of candidate 0 at 3
        repeat (3) vote(4'b0001, a);
        vote(4'b0001, a);
        chk("t4_ack_on_sat", a, 1); chk("t4_total", total, 5);
        chk("t4_saturated", saturated, 1); chk("t4_leader", leader, 0);

        // result-mode display with tallies 2/2/1/0
        do_reset();
        repeat (2) vote(4'b0001, a);
        repeat (2) vote(4'b0010, a);
        vote(4'b0100, a);
        mode = 1'b1; step(1);
        button = 4'b0010; step(DB + 2);
        chk("t5_led_c1", led, 2); chk("t5_leader", leader, 0); chk("t5_tie", tie, 1);
        button = 4'b0011; step(DB + 2);
        chk("t5_led_multi", led, 0);
        button = '0; mode = 1'b0; step(2);

        // reset during the sixth press cycle
        arm1(); button = 4'b0001; step(5);
        do_reset();
        chk("t6_armed", armed, 0); chk("t6_total", total, 0);
        chk("t6_tie", tie, 1); chk("t6_led", led, 0);
        step(DB + 5);
        chk("t6_no_vote", total, 0); chk("t6_still_idle", armed, 0);
        button = '0; step(2);

        // randomized ballots, cancellations, result views and resets
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1: begin arm = 1'b1; step($urandom_range(1, 2)); arm = 1'b0; end
                2, 3, 4, 5: begin
                    if ($urandom_range(0, 3) == 0) m = NC'($urandom);
                    else m = NC'(1 << $urandom_range(0, NC - 1));
                    arm = ($urandom_range(0, 3) == 0);
                    hold(m, $urandom_range(DB - 3, DB + 3));
                    arm = 1'b0;
                end
                6: begin
                    mode = 1'b1; button = NC'($urandom);
                    step($urandom_range(2, DB + 4));
                    button = '0; mode = 1'b0;
                end
                7, 8: step($urandom_range(1, 6));
                default: if ($urandom_range(0, 4) == 0) do_reset();
            endcase
        end
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/voting_machine_param.md
# voting_machine_param

Parametrised successor to the four-button voting machine: NUM_CAND candidate buttons with per-button debounce, officer-armed one-vote-per-ballot control, saturating per-candidate tallies, a running total, and a registered leader/tie indicator. Sits between the panel buttons/mode switch and the LED bank. In vote mode it drives ballot status on the LEDs; in result mode it displays the tally of the candidate whose button is held.

## Interface
- NUM_CAND, 4: number of candidates, 2..16.
- CNT_W, 8: per-candidate tally width; also the led width.
- DEBOUNCE_CYC, 10: consecutive high samples that qualify a press, at least 2.
- ACK_CYC, 4: length of the acknowledge hold-off, at least 1.
- IDX_W, $clog2(NUM_CAND): leader index width.
- TOT_W, CNT_W+$clog2(NUM_CAND): total width.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low; clears all state.
- mode  in  1  0 = vote, 1 = result.
- arm  in  1  officer ballot enable; level sampled each cycle.
- button  in  NUM_CAND  candidate buttons, already synchronous to clock.
- led  out  CNT_W  status or tally display.
- vote_ack  out  1  one-cycle pulse when a ballot is accepted.
- spoiled  out  1  one-cycle pulse when a ballot is rejected.
- armed  out  1  high while a ballot is open.
- total  out  TOT_W  count of accepted ballots that incremented a tally.
- leader  out  IDX_W  lowest index holding the maximum tally.
- tie  out  1  two or more candidates share the maximum.
- saturated  out  1  sticky; a vote hit a tally at 2^CNT_W-1.

## Operation
- Reset (reset=0 at an edge) clears the following:
  - All tallies, total, led, vote_ack, spoiled, armed, saturated and leader are 0.
  - tie is 1, because all tallies are equal at zero.
  - All debounce counters are 0 and the FSM is IDLE.
- Debounce, per button i:
  - dcnt[i] increments while button[i]=1 and saturates at DEBOUNCE_CYC.
  - dcnt[i] clears on any low sample.
  - press[i] is a one-cycle registered pulse on the 0 to 1 transition of dcnt[i]==DEBOUNCE_CYC.
  - held[i] = (dcnt[i]==DEBOUNCE_CYC).
  - A new press requires release followed by DEBOUNCE_CYC fresh high samples.
- Ballot FSM states: IDLE, ARMED, ACK.
  - IDLE to ARMED when arm=1 and mode=0. Presses in IDLE are ignored.
  - ARMED with exactly one press bit set:
    - tally[i]+1 and total+1 if tally[i] is below max.
    - Otherwise the tally and total are unchanged and saturated is set to 1.
    - In both cases vote_ack pulses and the FSM goes to ACK.
  - ARMED with two or more press bits in the same cycle: no tally change, spoiled pulses, FSM goes to IDLE.
  - ARMED with mode=1: the ballot is cancelled, FSM goes to IDLE, no pulse. Cancellation has priority over any press in the same cycle.
  - ACK: hold for ACK_CYC cycles, then go to IDLE. Presses during ACK are ignored.
  - The officer must re-arm for each ballot. A press does not open a new ballot even if arm is still high; IDLE re-evaluates arm on the cycle after ACK.
- led, vote mode:
  - IDLE: 0.
  - ARMED: 1 (bit 0 only).
  - ACK: all ones.
- led, result mode:
  - Exactly one held[i]: led = tally[i].
  - Zero or multiple held: led = 0.
  - The FSM stays IDLE in result mode.
- Leader and tie:
  - Registered from the current tallies.
  - leader is the lowest index with the maximum tally.
  - tie=1 when the count of candidates at the maximum is at least 2.
- Widths: tallies saturate and never wrap. total cannot overflow, because TOT_W covers NUM_CAND*(2^CNT_W-1).

## Timing
- Button first sampled high at edge k, and held:
  - dcnt reaches DEBOUNCE_CYC at edge k+DEBOUNCE_CYC-1.
  - press is high in the cycle after edge k+DEBOUNCE_CYC.
  - The tally, total and vote_ack update at edge k+DEBOUNCE_CYC+1.
  - The FSM is in ACK from the same edge.
- leader and tie lag the tallies by one cycle.
- vote_ack and spoiled are exactly one cycle wide and never high together.
- ACK lasts exactly ACK_CYC cycles; IDLE follows.
- armed goes high one cycle after arm is sampled in IDLE.
- Reset mid-ballot, at any state: everything clears at that edge and no partial tally is kept.
- A mode change takes effect on led the cycle after it is sampled.

## Test plan
- Reset, then arm=1 for one cycle, then hold button[2] for 10 cycles (defaults) -> vote_ack pulse, tally2=1, total=1, led=all ones for 4 cycles then 0, leader=2, tie=0.
- Arm, then press button[1] for only 9 cycles and release -> no ack, still ARMED; next press of 10 cycles -> tally1=1.
- Arm, then raise button[0] and button[3] on the same cycle for 10 cycles -> spoiled pulse, tallies unchanged, FSM IDLE.
- With CNT_W=2: give candidate 0 four accepted ballots -> tally0=3, total=3, saturated=1, vote_ack still pulses on the 4th ballot.
- Cast votes tallying 2/2/1/0, switch mode=1, hold button[1] -> led=2, leader=0, tie=1. Hold buttons 0 and 1 together -> led=0.
- Arm, then assert reset=0 during the 6th press cycle and release reset -> all outputs at reset values; the button continuing high counts from 0 and is ignored until a new arm.
